apb_timer_sequencer: RTL and testbench
======================================

# apb_timer_sequencer

APB master controller that programs and services the 64-bit APB timer without CPU involvement. On a start command it writes a fixed register script (disable, clear counter, load compare, enable interrupt, enable), waits for `tim_int`, clears the interrupt status, counts the event, and either re-arms (periodic) or shuts the timer down (one-shot). It sits between a local control interface and the timer's APB slave port.

## Interface
- `TMO_CYCLES`, 16: maximum ACCESS cycles waiting for `tim_pready` before the transfer is declared failed.
- `sys_clk` in 1: single clock; all logic is rising-edge.
- `sys_rst_n` in 1: asynchronous, active-low reset.
- `cfg_start` in 1: start pulse; sampled only in IDLE.
- `cfg_stop` in 1: stop request; level or pulse, latched while busy.
- `cfg_cmp` in 64: compare value, latched on accepted start.
- `cfg_div_val` in 4: divider value for TCR[11:8], latched on start.
- `cfg_div_en` in 1: TCR[1], latched on start.
- `cfg_periodic` in 1: 1 = re-arm after each interrupt, latched on start.
- `seq_busy` out 1: high whenever state is not IDLE.
- `seq_done` out 1: one-cycle pulse on a normal return to IDLE.
- `seq_err` out 1: sticky; set on `tim_pslverr` or timeout, cleared by the next accepted start.
- `event_cnt` out 16: interrupts serviced since the last start; wraps 0xFFFF→0x0000.
- `tim_psel`, `tim_penable`, `tim_pwrite` out 1: APB master controls.
- `tim_paddr` out 12, `tim_pwdata` out 32, `tim_pstrb` out 4: APB address, write data, strobe (always 4'hF).
- `tim_prdata` in 32, `tim_pready` in 1, `tim_pslverr` in 1: APB slave response.
- `tim_int` in 1: timer interrupt, level-high.

## Operation
- Register map: TCR 0x000 (bit0 timer_en, bit1 div_en, [11:8] div_val), TDR0 0x004, TDR1 0x008, TCMP0 0x00C, TCMP1 0x010, TIER 0x014 (bit0 int_en), TISR 0x018 (bit0, write-1-to-clear).
- FSM states: IDLE, SETUP, ACCESS, GAP, WAIT_INT. A step pointer selects the current script operation.
- Config script (all writes):
  - S0: TCR = {div_val, 6'h0, div_en, 0}
  - S1: TDR0 = 0
  - S2: TDR1 = 0
  - S3: TCMP0 = cmp[31:0]
  - S4: TCMP1 = cmp[63:32]
  - S5: TIER = 1
  - S6: TCR = {div_val, 6'h0, div_en, 1}
  - After S6 → WAIT_INT.
- Service script: S7 writes TISR = 1, then `event_cnt` increments. Next step:
  - stop latched → S9;
  - else periodic → re-arm S0, S1, S2, S6 (skip S3–S5) → WAIT_INT;
  - else → S9.
- Stop script: S9 writes TCR = {div_val, 6'h0, div_en, 0} → IDLE with `seq_done`.
- WAIT_INT: `tim_int` high → S7. Else if stop latched → S9.
- `tim_int` and stop in the same cycle: service first (S7), then S9; `event_cnt` still increments.
- Stop latched during config or re-arm: the script completes to S6, then goes straight to S9 without waiting for an interrupt.
- `cfg_start` while busy is ignored. The stop latch clears on entry to IDLE.
- Error: `tim_pslverr` high with `tim_pready`, or `TMO_CYCLES` ACCESS cycles without `tim_pready` → drop psel/penable, go to IDLE, set `seq_err`, no `seq_done`. The timer is left as-is.
- Reset mid-operation: all state and outputs return to reset values immediately; the bus is released.

## Timing
- Reset values: all outputs 0; `tim_paddr`/`tim_pwdata` 0; `tim_pstrb` 4'hF.
- All APB outputs are registered.
- Start accepted at edge N → SETUP from edge N+1: psel=1, penable=0, with address and data valid.
- ACCESS: psel=1, penable=1. Address, data and pwrite are held stable until `tim_pready` is sampled high.
- GAP: one cycle with psel=0 and penable=0 after every transfer. Minimum 3 cycles per transfer.
- Zero-wait-state slave, start to WAIT_INT: 21 cycles (7 transfers × 3).
- `tim_int` sampled at edge M → SETUP of S7 at M+1.
- `event_cnt` updates on the cycle the S7 GAP is entered.
- `seq_done` is asserted in the first IDLE cycle.
- Timeout counter resets on each SETUP.

## Test plan
- One-shot: div_en=0, cmp=64'h20, periodic=0 → exact write sequence S0–S6 observed.
  - Interrupt arrives, TISR cleared, `event_cnt`=1.
  - S9 TCR=0, then one `seq_done`; `seq_busy` low afterward.
- Periodic: cmp=64'h10, run until 5 interrupts → `event_cnt`=5.
  - Each re-arm writes only TCR, TDR0, TDR1, TCR.
  - Readback of TDR0 after re-arm < 0x10.
- Stop during config: assert `cfg_stop` during S2 → S6 completes, then S9 immediately.
  - `event_cnt`=0, `seq_done` pulses.
- Simultaneous `tim_int` and `cfg_stop` in WAIT_INT → S7 then S9; `event_cnt`=1; no re-arm even though periodic=1.
- Error paths:
  - Slave asserts `tim_pslverr` on S3 → bus released, `seq_err`=1, no `seq_done`.
  - Next start clears `seq_err`.
  - Slave holding `tim_pready`=0 for 16 cycles → same error response.
- Reset at random cycle inside ACCESS → all outputs 0 within the reset assertion, no further bus activity until a new start.

Source files
------------

// File: rtl/apb_timer_sequencer.sv
// apb_timer_sequencer: APB master that programs the 64-bit timer, services
// its interrupt, and either re-arms it (periodic) or shuts it down (one-shot).
module apb_timer_sequencer #(
  parameter int TMO_CYCLES = 16
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        cfg_start,
  input  logic        cfg_stop,
  input  logic [63:0] cfg_cmp,
  input  logic [3:0]  cfg_div_val,
  input  logic        cfg_div_en,
  input  logic        cfg_periodic,
  output logic        seq_busy,
  output logic        seq_done,
  output logic        seq_err,
  output logic [15:0] event_cnt,
  output logic        tim_psel,
  output logic        tim_penable,
  output logic        tim_pwrite,
  output logic [11:0] tim_paddr,
  output logic [31:0] tim_pwdata,
  output logic [3:0]  tim_pstrb,
  input  logic [31:0] tim_prdata,
  input  logic        tim_pready,
  input  logic        tim_pslverr,
  input  logic        tim_int
);

  typedef enum logic [2:0] {IDLE, SETUP, ACCESS, GAP, WAIT_INT} state_e;

  localparam int TMO_W = $clog2(TMO_CYCLES + 1);

  state_e             state_q;
  logic [3:0]         step_q, step_d;
  logic               rearm_q, rearm_d;
  logic               stop_q;
  logic               stop_now;
  logic               gap_idle, gap_wait;
  logic [TMO_W-1:0]   tmo_q;
  logic [63:0]        cmp_q;
  logic [3:0]         div_val_q;
  logic               div_en_q;
  logic               periodic_q;
  logic               done_q, err_q;
  logic [15:0]        event_cnt_q;
  logic               psel_q, penable_q, pwrite_q;
  logic [11:0]        paddr_q;
  logic [31:0]        pwdata_q;
  logic               prdata_unused;

  // The sequencer only ever writes, so read data is deliberately ignored.
  assign prdata_unused = ^tim_prdata;

  // Register offset addressed by each script step (S0..S7, S9).
  function automatic logic [11:0] stepAddr(input logic [3:0] step);
    case (step)
      4'd1:    stepAddr = 12'h004;
      4'd2:    stepAddr = 12'h008;
      4'd3:    stepAddr = 12'h00C;
      4'd4:    stepAddr = 12'h010;
      4'd5:    stepAddr = 12'h014;
      4'd7:    stepAddr = 12'h018;
      default: stepAddr = 12'h000;
    endcase
  endfunction

  // Write data of each script step; TCR carries divider settings, bit0 = enable.
  function automatic logic [31:0] stepData(input logic [3:0] step, input logic [63:0] cmp,
                                           input logic [3:0] div_val, input logic div_en);
    logic [31:0] tcr;
    tcr = {20'h0, div_val, 6'h0, div_en, 1'b0};
    case (step)
      4'd0, 4'd9: stepData = tcr;
      4'd6:       stepData = tcr | 32'h1;
      4'd3:       stepData = cmp[31:0];
      4'd4:       stepData = cmp[63:32];
      4'd5, 4'd7: stepData = 32'h1;
      default:    stepData = 32'h0;
    endcase
  endfunction

  // Decide what follows the current step once its GAP cycle is reached.
  always_comb begin
    stop_now = stop_q | cfg_stop;
    step_d   = step_q;
    rearm_d  = rearm_q;
    gap_idle = 1'b0;
    gap_wait = 1'b0;
    case (step_q)
      4'd0: step_d = 4'd1;
      4'd1: step_d = 4'd2;
      4'd2: step_d = rearm_q ? 4'd6 : 4'd3;
      4'd3: step_d = 4'd4;
      4'd4: step_d = 4'd5;
      4'd5: step_d = 4'd6;
      4'd6: begin
        rearm_d = 1'b0;
        if (stop_now) step_d = 4'd9;
        else          gap_wait = 1'b1;
      end
      4'd7: begin
        if (stop_now || !periodic_q) begin
          step_d = 4'd9;
        end else begin
          step_d  = 4'd0;
          rearm_d = 1'b1;
        end
      end
      default: gap_idle = 1'b1;
    endcase
  end

  // Main sequencer FSM: drives the APB master and the status outputs.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= IDLE;
      step_q      <= 4'd0;
      rearm_q     <= 1'b0;
      stop_q      <= 1'b0;
      tmo_q       <= '0;
      cmp_q       <= 64'h0;
      div_val_q   <= 4'h0;
      div_en_q    <= 1'b0;
      periodic_q  <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      event_cnt_q <= 16'h0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= 12'h0;
      pwdata_q    <= 32'h0;
    end else begin
      done_q <= 1'b0;
      if (state_q != IDLE && cfg_stop) stop_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (cfg_start) begin
            cmp_q       <= cfg_cmp;
            div_val_q   <= cfg_div_val;
            div_en_q    <= cfg_div_en;
            periodic_q  <= cfg_periodic;
            err_q       <= 1'b0;
            event_cnt_q <= 16'h0;
            stop_q      <= 1'b0;
            rearm_q     <= 1'b0;
            step_q      <= 4'd0;
            psel_q      <= 1'b1;
            pwrite_q    <= 1'b1;
            paddr_q     <= stepAddr(4'd0);
            pwdata_q    <= stepData(4'd0, cfg_cmp, cfg_div_val, cfg_div_en);
            state_q     <= SETUP;
          end
        end
        SETUP: begin
          penable_q <= 1'b1;
          tmo_q     <= '0;
          state_q   <= ACCESS;
        end
        ACCESS: begin
          if ((tim_pready && tim_pslverr) ||
              (!tim_pready && tmo_q == TMO_W'(TMO_CYCLES - 1))) begin
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            err_q     <= 1'b1;
            stop_q    <= 1'b0;
            state_q   <= IDLE;
          end else if (tim_pready) begin
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            if (step_q == 4'd7) event_cnt_q <= event_cnt_q + 16'h1;
            state_q   <= GAP;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        GAP: begin
          if (gap_idle) begin
            done_q  <= 1'b1;
            stop_q  <= 1'b0;
            state_q <= IDLE;
          end else if (gap_wait) begin
            rearm_q <= 1'b0;
            state_q <= WAIT_INT;
          end else begin
            step_q   <= step_d;
            rearm_q  <= rearm_d;
            psel_q   <= 1'b1;
            pwrite_q <= 1'b1;
            paddr_q  <= stepAddr(step_d);
            pwdata_q <= stepData(step_d, cmp_q, div_val_q, div_en_q);
            state_q  <= SETUP;
          end
        end
        WAIT_INT: begin
          if (tim_int || stop_now) begin
            step_q   <= tim_int ? 4'd7 : 4'd9;
            psel_q   <= 1'b1;
            pwrite_q <= 1'b1;
            paddr_q  <= stepAddr(tim_int ? 4'd7 : 4'd9);
            pwdata_q <= stepData(tim_int ? 4'd7 : 4'd9, cmp_q, div_val_q, div_en_q);
            state_q  <= SETUP;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign seq_busy    = (state_q != IDLE);
  assign seq_done    = done_q;
  assign seq_err     = err_q;
  assign event_cnt   = event_cnt_q;
  assign tim_psel    = psel_q;
  assign tim_penable = penable_q;
  assign tim_pwrite  = pwrite_q;
  assign tim_paddr   = paddr_q;
  assign tim_pwdata  = pwdata_q;
  assign tim_pstrb   = 4'hF;

endmodule

// File: tb/tb_apb_timer_sequencer.sv
// tb_apb_timer_sequencer: drives the sequencer against a behavioural APB timer
// slave and compares every completed write against a script built from the
// register map rules.
module tb_apb_timer_sequencer;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        cfg_start = 1'b0;
  logic        cfg_stop = 1'b0;
  logic [63:0] cfg_cmp = 64'h0;
  logic [3:0]  cfg_div_val = 4'h0;
  logic        cfg_div_en = 1'b0;
  logic        cfg_periodic = 1'b0;
  logic        seq_busy, seq_done, seq_err;
  logic [15:0] event_cnt;
  logic        tim_psel, tim_penable, tim_pwrite;
  logic [11:0] tim_paddr;
  logic [31:0] tim_pwdata;
  logic [3:0]  tim_pstrb;
  logic [31:0] tim_prdata = 32'h0;
  logic        tim_pready = 1'b0;
  logic        tim_pslverr = 1'b0;
  logic        tim_int = 1'b0;

  typedef struct packed {
    logic [11:0] addr;
    logic [31:0] data;
    logic        wr;
    logic [3:0]  strb;
  } wr_t;

  wr_t         logQ[$];
  wr_t         expQ[$];
  int          checks = 0;
  int          errors = 0;
  int          doneCount = 0;
  int          xferIdx = 0;
  int          hangCycles = 0;
  int          waitTarget = 0;
  int          wcnt = 0;
  int          errIdx = -1;
  int          hangIdx = -1;
  int unsigned maxWait = 0;
  logic [63:0] mCmp;
  logic [3:0]  mDivVal;
  logic        mDivEn;

  apb_timer_sequencer #(.TMO_CYCLES(16)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .cfg_start(cfg_start), .cfg_stop(cfg_stop), .cfg_cmp(cfg_cmp),
    .cfg_div_val(cfg_div_val), .cfg_div_en(cfg_div_en), .cfg_periodic(cfg_periodic),
    .seq_busy(seq_busy), .seq_done(seq_done), .seq_err(seq_err), .event_cnt(event_cnt),
    .tim_psel(tim_psel), .tim_penable(tim_penable), .tim_pwrite(tim_pwrite),
    .tim_paddr(tim_paddr), .tim_pwdata(tim_pwdata), .tim_pstrb(tim_pstrb),
    .tim_prdata(tim_prdata), .tim_pready(tim_pready), .tim_pslverr(tim_pslverr),
    .tim_int(tim_int)
  );

  always #5 sys_clk = ~sys_clk;

  // Slave response: random wait states, optional error or hang on one transfer.
  always @(negedge sys_clk) begin
    if (tim_psel && tim_penable) begin
      if (xferIdx == hangIdx) begin
        tim_pready  = 1'b0;
        tim_pslverr = 1'b0;
      end else if (wcnt >= waitTarget) begin
        tim_pready  = 1'b1;
        tim_pslverr = (xferIdx == errIdx);
      end else begin
        tim_pready  = 1'b0;
        tim_pslverr = 1'b0;
        wcnt++;
      end
    end else begin
      tim_pready  = 1'b0;
      tim_pslverr = 1'b0;
      wcnt        = 0;
    end
  end

  // Bus monitor: logs completed writes, counts done pulses and hung ACCESS cycles.
  always @(posedge sys_clk) begin
    if (sys_rst_n && cfg_start && !seq_busy) begin
      logQ.delete();
      xferIdx    = 0;
      hangCycles = 0;
      doneCount  = 0;
      waitTarget = $urandom_range(0, maxWait);
    end else if (sys_rst_n) begin
      if (seq_done) doneCount++;
      if (tim_psel && tim_penable) begin
        if (xferIdx == hangIdx) begin
          hangCycles++;
        end else if (tim_pready) begin
          if (!tim_pslverr) logQ.push_back({tim_paddr, tim_pwdata, tim_pwrite, tim_pstrb});
          xferIdx++;
          waitTarget = $urandom_range(0, maxWait);
        end
      end
    end
  end

  // Reference model of the register script, from the timer register map.
  function automatic logic [31:0] tcrVal(input logic en);
    return (32'(mDivVal) << 8) | (32'(mDivEn) << 1) | 32'(en);
  endfunction

  function automatic void expPush(input logic [11:0] a, input logic [31:0] d);
    expQ.push_back({a, d, 1'b1, 4'hF});
  endfunction

  function automatic void expConfig();
    expPush(12'h000, tcrVal(1'b0));
    expPush(12'h004, 32'h0);
    expPush(12'h008, 32'h0);
    expPush(12'h00C, mCmp[31:0]);
    expPush(12'h010, mCmp[63:32]);
    expPush(12'h014, 32'h1);
    expPush(12'h000, tcrVal(1'b1));
  endfunction

  function automatic void expRearm();
    expPush(12'h000, tcrVal(1'b0));
    expPush(12'h004, 32'h0);
    expPush(12'h008, 32'h0);
    expPush(12'h000, tcrVal(1'b1));
  endfunction

  function automatic void expService();
    expPush(12'h018, 32'h1);
  endfunction

  function automatic void expStop();
    expPush(12'h000, tcrVal(1'b0));
  endfunction

  // Index of the first differing write, -1 when the logs agree exactly.
  function automatic int logDiff();
    int n;
    n = (logQ.size() < expQ.size()) ? logQ.size() : expQ.size();
    for (int i = 0; i < n; i++)
      if (logQ[i] !== expQ[i]) return i;
    if (logQ.size() != expQ.size()) return n;
    return -1;
  endfunction

  task automatic waitLog(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (logQ.size() >= n) begin
        ok = 1'b1;
        break;
      end
      @(negedge sys_clk);
    end
  endtask

  task automatic waitIdle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (!seq_busy) begin
        ok = 1'b1;
        break;
      end
      @(negedge sys_clk);
    end
  endtask

  task automatic startRun(input logic [63:0] cmp, input logic [3:0] dv, input logic de,
                          input logic per);
    mCmp = cmp; mDivVal = dv; mDivEn = de;
    expQ.delete();
    cfg_cmp = cmp; cfg_div_val = dv; cfg_div_en = de; cfg_periodic = per;
    cfg_start = 1'b1;
    @(negedge sys_clk);
    cfg_start = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if ({tim_psel, tim_penable, tim_pwrite, seq_busy, seq_done, seq_err} !== 6'b0) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: got %b expected 000000",
               {tim_psel, tim_penable, tim_pwrite, seq_busy, seq_done, seq_err});
    end
    checks++;
    if (tim_paddr !== 12'h0 || tim_pwdata !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_addr_data: got %h/%h expected 000/00000000", tim_paddr, tim_pwdata);
    end
    checks++;
    if (tim_pstrb !== 4'hF) begin
      errors++;
      $display("[TB] FAIL reset_pstrb: got %h expected f", tim_pstrb);
    end
    checks++;
    if (event_cnt !== 16'h0) begin
      errors++;
      $display("[TB] FAIL reset_event_cnt: got %0d expected 0", event_cnt);
    end
    sys_rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);
    checks++;
    if (seq_busy !== 1'b0 || tim_psel !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_release_idle: busy=%b psel=%b expected 0/0", seq_busy, tim_psel);
    end
  endtask

  task automatic test_oneshot();
    int cycles;
    int d;
    bit ok;
    maxWait = 0;
    startRun(64'h20, 4'($urandom_range(0, 15)), 1'b0, 1'b0);
    expConfig();
    checks++;
    if ({tim_psel, tim_penable, tim_pwrite, seq_busy} !== 4'b1011 ||
        tim_paddr !== 12'h000 || tim_pwdata !== tcrVal(1'b0)) begin
      errors++;
      $display("[TB] FAIL oneshot_first_setup: sel/en/wr/busy=%b addr=%h data=%h expected 1011/000/%h",
               {tim_psel, tim_penable, tim_pwrite, seq_busy}, tim_paddr, tim_pwdata, tcrVal(1'b0));
    end
    cycles = 0;
    while (logQ.size() < 7 && cycles < 200) begin
      @(negedge sys_clk);
      cycles++;
    end
    checks++;
    if (cycles !== 20) begin
      errors++;
      $display("[TB] FAIL oneshot_config_latency: got %0d cycles expected 20", cycles);
    end
    repeat (3) @(negedge sys_clk);
    checks++;
    if (seq_busy !== 1'b1 || tim_psel !== 1'b0 || logQ.size() !== 7) begin
      errors++;
      $display("[TB] FAIL oneshot_wait_int: busy=%b psel=%b writes=%0d expected 1/0/7",
               seq_busy, tim_psel, logQ.size());
    end
    tim_int = 1'b1;
    expService();
    waitLog(8, 200, ok);
    tim_int = 1'b0;
    expStop();
    waitIdle(300, ok);
    repeat (3) @(negedge sys_clk);
    checks++;
    if (!ok || seq_busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL oneshot_idle: busy=%b expected 0", seq_busy);
    end
    checks++;
    if (event_cnt !== 16'd1 || doneCount !== 1 || seq_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL oneshot_status: evt=%0d done=%0d err=%b expected 1/1/0",
               event_cnt, doneCount, seq_err);
    end
    d = logDiff();
    checks++;
    if (d != -1) begin
      errors++;
      $display("[TB] FAIL oneshot_log: entry %0d differs, got %0d writes expected %0d",
               d, logQ.size(), expQ.size());
    end
  endtask

  task automatic test_periodic();
    int d;
    bit ok;
    maxWait = 3;
    startRun(64'h10, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'b1);
    expConfig();
    for (int k = 0; k < 5; k++) begin
      waitLog(expQ.size(), 400, ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("[TB] FAIL periodic_arm_%0d: got %0d writes expected %0d", k, logQ.size(), expQ.size());
      end
      repeat (2) @(negedge sys_clk);
      tim_int = 1'b1;
      expService();
      waitLog(expQ.size(), 400, ok);
      tim_int = 1'b0;
      expRearm();
    end
    repeat (3) @(negedge sys_clk);
    cfg_stop = 1'b1;
    @(negedge sys_clk);
    cfg_stop = 1'b0;
    expStop();
    waitIdle(600, ok);
    repeat (3) @(negedge sys_clk);
    checks++;
    if (!ok || event_cnt !== 16'd5 || doneCount !== 1) begin
      errors++;
      $display("[TB] FAIL periodic_status: idle=%b evt=%0d done=%0d expected 1/5/1",
               ok, event_cnt, doneCount);
    end
    d = logDiff();
    checks++;
    if (d != -1) begin
      errors++;
      $display("[TB] FAIL periodic_log: entry %0d differs, got %0d writes expected %0d",
               d, logQ.size(), expQ.size());
    end
  endtask

  task automatic test_stop_config();
    int d;
    bit ok;
    maxWait = 2;
    startRun({$urandom, $urandom}, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'b1);
    expConfig();
    expStop();
    waitLog(2, 200, ok);
    @(negedge sys_clk);
    cfg_stop = 1'b1;
    @(negedge sys_clk);
    cfg_stop = 1'b0;
    waitIdle(300, ok);
    repeat (3) @(negedge sys_clk);
    checks++;
    if (!ok || event_cnt !== 16'd0 || doneCount !== 1) begin
      errors++;
      $display("[TB] FAIL stop_config_status: idle=%b evt=%0d done=%0d expected 1/0/1",
               ok, event_cnt, doneCount);
    end
    d = logDiff();
    checks++;
    if (d != -1) begin
      errors++;
      $display("[TB] FAIL stop_config_log: entry %0d differs, got %0d writes expected %0d",
               d, logQ.size(), expQ.size());
    end
  endtask

  task automatic test_int_stop();
    int d;
    bit ok;
    maxWait = 2;
    startRun({$urandom, $urandom}, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'b1);
    expConfig();
    expService();
    expStop();
    waitLog(7, 300, ok);
    repeat (2) @(negedge sys_clk);
    tim_int  = 1'b1;
    cfg_stop = 1'b1;
    @(negedge sys_clk);
    tim_int  = 1'b0;
    cfg_stop = 1'b0;
    waitIdle(300, ok);
    repeat (3) @(negedge sys_clk);
    checks++;
    if (!ok || event_cnt !== 16'd1 || doneCount !== 1) begin
      errors++;
      $display("[TB] FAIL int_stop_status: idle=%b evt=%0d done=%0d expected 1/1/1",
               ok, event_cnt, doneCount);
    end
    d = logDiff();
    checks++;
    if (d != -1) begin
      errors++;
      $display("[TB] FAIL int_stop_log: entry %0d differs, got %0d writes expected %0d",
               d, logQ.size(), expQ.size());
    end
  endtask

  task automatic test_slverr();
    int d;
    bit ok;
    maxWait = 1;
    errIdx  = 3;
    startRun({$urandom, $urandom}, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'b0);
    expPush(12'h000, tcrVal(1'b0));
    expPush(12'h004, 32'h0);
    expPush(12'h008, 32'h0);
    waitIdle(300, ok);
    repeat (3) @(negedge sys_clk);
    errIdx = -1;
    checks++;
    if (!ok || seq_err !== 1'b1 || tim_psel !== 1'b0 || tim_penable !== 1'b0) begin
      errors++;
      $display("[TB] FAIL slverr_release: idle=%b err=%b psel=%b penable=%b expected 1/1/0/0",
               ok, seq_err, tim_psel, tim_penable);
    end
    checks++;
    if (doneCount !== 0) begin
      errors++;
      $display("[TB] FAIL slverr_no_done: got %0d done pulses expected 0", doneCount);
    end
    d = logDiff();
    checks++;
    if (d != -1) begin
      errors++;
      $display("[TB] FAIL slverr_log: entry %0d differs, got %0d writes expected %0d",
               d, logQ.size(), expQ.size());
    end
  endtask

  task automatic test_err_clear();
    bit ok;
    maxWait = 0;
    startRun({$urandom, $urandom}, 4'($urandom_range(0, 15)), 1'b0, 1'b0);
    checks++;
    if (seq_err !== 1'b0 || seq_busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL err_clear: err=%b busy=%b expected 0/1", seq_err, seq_busy);
    end
    waitLog(3, 200, ok);
    cfg_stop = 1'b1;
    @(negedge sys_clk);
    cfg_stop = 1'b0;
    waitIdle(300, ok);
    repeat (3) @(negedge sys_clk);
    checks++;
    if (!ok || doneCount !== 1 || seq_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL err_clear_finish: idle=%b done=%0d err=%b expected 1/1/0",
               ok, doneCount, seq_err);
    end
  endtask

  task automatic test_timeout();
    int d;
    bit ok;
    maxWait = 0;
    hangIdx = 1;
    startRun({$urandom, $urandom}, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'b1);
    expPush(12'h000, tcrVal(1'b0));
    waitIdle(300, ok);
    repeat (3) @(negedge sys_clk);
    hangIdx = -1;
    checks++;
    if (hangCycles !== 16) begin
      errors++;
      $display("[TB] FAIL timeout_cycles: got %0d access cycles expected 16", hangCycles);
    end
    checks++;
    if (!ok || seq_err !== 1'b1 || tim_psel !== 1'b0 || tim_penable !== 1'b0 || doneCount !== 0) begin
      errors++;
      $display("[TB] FAIL timeout_release: idle=%b err=%b psel=%b penable=%b done=%0d expected 1/1/0/0/0",
               ok, seq_err, tim_psel, tim_penable, doneCount);
    end
    d = logDiff();
    checks++;
    if (d != -1) begin
      errors++;
      $display("[TB] FAIL timeout_log: entry %0d differs, got %0d writes expected %0d",
               d, logQ.size(), expQ.size());
    end
  endtask

  task automatic test_reset_mid();
    int n;
    int activity;
    bit found;
    maxWait = 3;
    startRun({$urandom, $urandom}, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'b1);
    n = $urandom_range(2, 40);
    found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge sys_clk);
      if (i >= n && tim_penable) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("[TB] FAIL reset_mid_access: got no ACCESS cycle expected one");
    end
    #2 sys_rst_n = 1'b0;
    #1;
    checks++;
    if ({tim_psel, tim_penable, tim_pwrite, seq_busy, seq_done, seq_err} !== 6'b0 ||
        tim_paddr !== 12'h0 || tim_pwdata !== 32'h0 || tim_pstrb !== 4'hF || event_cnt !== 16'h0) begin
      errors++;
      $display("[TB] FAIL reset_mid_outputs: ctrl=%b addr=%h data=%h strb=%h evt=%0d expected 000000/000/00000000/f/0",
               {tim_psel, tim_penable, tim_pwrite, seq_busy, seq_done, seq_err},
               tim_paddr, tim_pwdata, tim_pstrb, event_cnt);
    end
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    activity = 0;
    repeat (30) begin
      @(negedge sys_clk);
      if (tim_psel || seq_busy) activity++;
    end
    checks++;
    if (activity !== 0) begin
      errors++;
      $display("[TB] FAIL reset_mid_quiet: got %0d active cycles expected 0", activity);
    end
  endtask

  initial begin
    repeat (3) @(negedge sys_clk);
    test_reset();
    test_oneshot();
    test_periodic();
    test_stop_config();
    test_int_stop();
    test_slverr();
    test_err_clear();
    test_timeout();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
